// File: rtl/r4k_mem_arbiter.sv
// r4k_mem_arbiter
// ---------------
// Shares one 64-bit memory bus between the R4K instruction-fetch port and
// data port. One transaction is in flight at a time. Every transaction is
// bounded by a response timeout that completes it with an error flag.
//
// Build option:
//   R4K_ARB_ROUND_ROBIN_EN  - when defined, a tie between both ports goes to
//                             the port not granted last. When undefined, the
//                             data port always wins.
//
// Parameters:
//   TIMEOUT   max cycles from issue to response (2..65535)
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   i_req/i_addr -> i_gnt            instruction read request / accept
//   i_rvalid/i_rdata/i_err           instruction response (1-cycle pulse)
//   d_req/d_we/d_addr/d_wdata/d_mask data request
//   d_gnt                            data request accepted
//   d_rvalid/d_rdata/d_err           data completion (1-cycle pulse)
//   m_req/m_we/m_addr/m_wdata/m_mask memory request, held until m_ready
//   m_ready, m_rvalid, m_rdata       memory accept / response
//   busy                             high whenever the FSM is not idle
//
// Handshake: a port's request is accepted in the cycle its gnt is high (only
// possible while idle). The memory request is accepted on the cycle m_req
// and m_ready are both high; m_rvalid is honoured only after that accept.

module r4k_mem_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [7:0]  d_mask,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        d_err,

    output logic        m_req,
    output logic        m_we,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    output logic [7:0]  m_mask,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [63:0] m_rdata,

    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] count;
    logic        owner_d;   // 1: data port owns the transaction
    logic        word_hi;   // captured i_addr[2] for the word select
    logic        grant_i;
    logic        grant_d;
    logic        resp_ok;
    logic        expired;

    // Low address bits are don't-care by definition of the ports.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[2:0]};

`ifdef R4K_ARB_ROUND_ROBIN_EN
    logic last_d;           // 1: the data port received the last grant

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == ST_IDLE) begin
            if (i_req && d_req) begin
                grant_d = !last_d;
                grant_i = last_d;
            end else begin
                grant_d = d_req;
                grant_i = i_req;
            end
        end
    end

    // Reset value "last = instruction" makes data win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_d <= 1'b0;
        end else if (grant_i || grant_d) begin
            last_d <= grant_d;
        end
    end
`else
    always_comb begin
        grant_d = (state == ST_IDLE) && d_req;
        grant_i = (state == ST_IDLE) && i_req && !d_req;
    end
`endif

    assign i_gnt = grant_i;
    assign d_gnt = grant_d;
    assign m_req = (state == ST_ISSUE);
    assign busy  = (state != ST_IDLE);

    // A response only counts once the request has been accepted; a response
    // landing on the expiry cycle beats the timeout.
    assign resp_ok = (state == ST_WAIT) && m_rvalid;
    assign expired = ((state == ST_ISSUE) || (state == ST_WAIT)) &&
                     (count == TO_LAST) && !resp_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            owner_d  <= 1'b0;
            word_hi  <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_mask   <= '0;
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            i_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            // Response outputs are single-cycle pulses and zero otherwise.
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            i_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        m_we    <= d_we;
                        m_addr  <= {d_addr[63:3], 3'b000};
                        m_wdata <= d_wdata;
                        m_mask  <= d_mask;
                        owner_d <= 1'b1;
                        word_hi <= 1'b0;
                        count   <= '0;
                        state   <= ST_ISSUE;
                    end else if (grant_i) begin
                        m_we    <= 1'b0;
                        m_addr  <= {i_addr[63:3], 3'b000};
                        m_wdata <= '0;
                        m_mask  <= 8'hFF;
                        owner_d <= 1'b0;
                        word_hi <= i_addr[2];
                        count   <= '0;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    count <= count + 16'd1;
                    if (expired) begin
                        state <= ST_IDLE;
                    end else if (m_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    count <= count + 16'd1;
                    if (resp_ok || expired) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (resp_ok || expired) begin
                if (owner_d) begin
                    d_rvalid <= 1'b1;
                    d_err    <= expired;
                    if (resp_ok && !m_we) begin
                        d_rdata <= m_rdata;
                    end
                end else begin
                    i_rvalid <= 1'b1;
                    i_err    <= expired;
                    if (resp_ok) begin
                        i_rdata <= word_hi ? m_rdata[63:32] : m_rdata[31:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_r4k_mem_arbiter.sv
// tb_r4k_mem_arbiter
// ------------------
// Bench for r4k_mem_arbiter, built with TIMEOUT = 8. Each transaction is
// described by when memory accepts and when it responds; the expected grant,
// bus activity and completion (cycle, port, data, error) are computed from
// those times with plain arithmetic. Completions go into an expected queue
// that a negedge monitor drains.

module tb_r4k_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_mask;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_mask;
    logic        m_ready;
    logic        m_rvalid;
    logic [63:0] m_rdata;
    logic        busy;

    r4k_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_mask   (d_mask),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_mask   (m_mask),
        .m_ready  (m_ready),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .busy     (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];      // expected response data
    int          exp_cyc_q[$];  // cycle in which the pulse must be visible
    logic        exp_err_q[$];
    logic        exp_port_q[$]; // 1 = data port

    bit last_was_d = 1'b0;      // model: data port received the last grant
    bit mon_en = 1'b0;

    always @(negedge clk) begin : monitor
        logic exp_i;
        logic exp_d;
        if (mon_en) begin
            exp_i = 1'b0;
            exp_d = 1'b0;
            while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
                void'(exp_err_q.pop_front());
                void'(exp_port_q.pop_front());
            end
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                if (exp_port_q[0]) exp_d = 1'b1;
                else               exp_i = 1'b1;
            end
            check("i_rvalid", i_rvalid, exp_i);
            check("d_rvalid", d_rvalid, exp_d);
            if (exp_i) begin
                check("i_rdata", i_rdata, exp_q[0]);
                check("i_err", i_err, exp_err_q[0]);
            end else begin
                check("i_rdata_idle", i_rdata, 0);
                check("i_err_idle", i_err, 0);
            end
            if (exp_d) begin
                check("d_rdata", d_rdata, exp_q[0]);
                check("d_err", d_err, exp_err_q[0]);
            end else begin
                check("d_rdata_idle", d_rdata, 0);
                check("d_err_idle", d_err, 0);
            end
            if (exp_i || exp_d) begin
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
                void'(exp_err_q.pop_front());
                void'(exp_port_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Cycle 0 is the grant cycle. Memory accepts at cycle 1+rw and responds
    // rv cycles after the accept cycle's successor (rv < 0: never).
    task automatic run_txn(input bit i_on, input bit d_on,
                           input logic [63:0] ia, input logic [63:0] da,
                           input bit dwe, input logic [63:0] dwd,
                           input logic [7:0] dmask, input logic [63:0] mrd,
                           input int rw, input int rv);
        bit          win_d;
        int          a, r, done, last, m_end;
        logic [63:0] exp_data;
        bit          exp_err;
`ifdef R4K_ARB_ROUND_ROBIN_EN
        win_d = d_on && (!i_on || !last_was_d);
`else
        win_d = d_on;
`endif
        last_was_d = win_d;
        a = 1 + rw;
        r = (rv >= 0) ? a + 1 + rv : -1;
        // Timeout fires at cycle TO (counter reaches TO-1); a response in
        // WAIT at or before that cycle wins.
        if (rv >= 0 && r <= TO) begin
            done    = r + 1;
            exp_err = 1'b0;
            if (win_d) exp_data = dwe ? 64'h0 : mrd;
            else       exp_data = ia[2] ? {32'h0, mrd[63:32]} : {32'h0, mrd[31:0]};
        end else begin
            done     = TO + 1;
            exp_err  = 1'b1;
            exp_data = 64'h0;
        end
        m_end = (a < TO) ? a : TO;
        last  = done - 1;
        if (r > last) last = r;

        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                exp_q.push_back(exp_data);
                exp_cyc_q.push_back(cyc + done);
                exp_err_q.push_back(exp_err);
                exp_port_q.push_back(win_d);
                i_req   = i_on;
                d_req   = d_on;
                i_addr  = ia;
                d_addr  = da;
                d_we    = dwe;
                d_wdata = dwd;
                d_mask  = dmask;
            end else if (k < done) begin
                // Winner drops and scrambles its fields; loser keeps asking.
                if (win_d) begin
                    d_req   = 1'b0;
                    d_addr  = {$urandom, $urandom};
                    d_wdata = {$urandom, $urandom};
                    d_mask  = 8'($urandom);
                    d_we    = 1'($urandom);
                end else begin
                    i_req  = 1'b0;
                    i_addr = {$urandom, $urandom};
                end
            end else begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            m_ready  = (k == a);
            m_rvalid = (k == r);
            m_rdata  = (k == r) ? mrd : {$urandom, $urandom};

            @(negedge clk);
            check("i_gnt", i_gnt, (k == 0) && !win_d);
            check("d_gnt", d_gnt, (k == 0) && win_d);
            check("m_req", m_req, (k >= 1) && (k <= m_end));
            check("busy", busy, (k >= 1) && (k < done));
            if (k >= 1 && k <= m_end) begin
                check("m_addr", m_addr, (win_d ? da : ia) & ~64'h7);
                check("m_mask", m_mask, win_d ? dmask : 8'hFF);
                check("m_we", m_we, win_d && dwe);
                if (win_d) check("m_wdata", m_wdata, dwd);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            i_req    = 1'b0;
            d_req    = 1'b0;
            m_ready  = 1'($urandom_range(0, 1));
            m_rvalid = 1'($urandom_range(0, 1));
            m_rdata  = {$urandom, $urandom};
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_m_req", m_req, 0);
        end
    endtask

    // Abandon a data read in WAIT via reset, then send a stray response.
    task automatic reset_in_wait();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h88; d_mask = 8'hFF;
        m_ready = 1'b0; m_rvalid = 1'b0;
        @(negedge clk);
        check("rst_d_gnt", d_gnt, 1);
        @(posedge clk); #1;
        d_req = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("rst_busy_wait", busy, 1);
        check("rst_m_req_wait", m_req, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_was_d = 1'b0;
        @(negedge clk);
        check("rst_busy_after", busy, 0);
        @(posedge clk); #1;
        m_rvalid = 1'b1; m_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        check("rst_busy_late", busy, 0);
        check("rst_m_req_late", m_req, 0);
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        @(negedge clk);
        check("rst_busy_post", busy, 0);
        check("rst_m_req_post", m_req, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_mask = '0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;

        @(posedge clk);
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_i_gnt", i_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_m_req", m_req, 0);
        check("rst_busy", busy, 0);
        check("rst_m_we", m_we, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_m_mask", m_mask, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Both ports asking, four back-to-back rounds.
        for (int n = 0; n < 4; n++) begin
            run_txn(1'b1, 1'b1, 64'h2000 + 64'(n * 4), 64'h3000 + 64'(n * 8), 1'b0,
                    64'h0, 8'hFF, {$urandom, $urandom}, 0, 0);
        end

        // Instruction read of the upper word.
        run_txn(1'b1, 1'b0, 64'h1004, 64'h0, 1'b0, 64'h0, 8'h00,
                64'hAAAA_BBBB_CCCC_DDDD, 0, 0);
        // Data write with m_ready held off for four cycles.
        run_txn(1'b0, 1'b1, 64'h0, 64'h20, 1'b1, 64'h1122_3344_5566_7788, 8'h0F,
                64'h5555_6666_7777_8888, 4, 0);
        // Timeout, late response two cycles after expiry.
        run_txn(1'b0, 1'b1, 64'h0, 64'h40, 1'b0, 64'h0, 8'hFF,
                64'h0123_4567_89AB_CDEF, 0, TO);
        // Response on the expiry cycle, data and instruction ports.
        run_txn(1'b0, 1'b1, 64'h0, 64'h48, 1'b0, 64'h0, 8'hFF,
                64'hFEDC_BA98_7654_3210, 0, TO - 2);
        run_txn(1'b1, 1'b0, 64'h1000, 64'h0, 1'b0, 64'h0, 8'h00,
                64'h1357_9BDF_2468_ACE0, 0, TO - 2);
        // Timeout while memory never accepts.
        run_txn(1'b1, 1'b0, 64'h1008, 64'h0, 1'b0, 64'h0, 8'h00,
                64'h0, TO + 2, -1);
        idle(2);

        reset_in_wait();
        idle(2);

        for (int t = 0; t < 150; t++) begin
            int sel;
            sel = $urandom_range(0, 2);
            run_txn(sel != 1, sel != 0, {$urandom, $urandom}, {$urandom, $urandom},
                    1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
                    {$urandom, $urandom}, $urandom_range(0, TO),
                    int'($urandom_range(0, TO + 1)) - 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
